// File: rtl/adma_pkg.sv
// Shared types and helpers for the AXIS destination data mover.
// atx_info_t documents the info-FIFO entry layout at the default configuration.
package adma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } dst_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_CHN_NUM  = 4;
  localparam int unsigned DEF_CHN_W    = clog2_min1(DEF_CHN_NUM);
  localparam int unsigned DEF_TDEST_W  = 2;
  localparam int unsigned DEF_LEN_W    = 8;
  localparam int unsigned DEF_BYTE_AMT = 256 / 8;

  typedef struct packed {
    logic [DEF_CHN_W-1:0]    chn_id;
    logic [DEF_TDEST_W-1:0]  tdest;
    logic [DEF_LEN_W-1:0]    tlen;
    logic [DEF_BYTE_AMT-1:0] tkeep_last;
  } atx_info_t;

  function automatic int unsigned info_width(input int unsigned chn_w, input int unsigned tdest_w,
                                             input int unsigned len_w, input int unsigned byte_amt);
    return chn_w + tdest_w + len_w + byte_amt;
  endfunction

endpackage

// File: rtl/adma_dst_pkt_ctrl.sv
// Packet framing controller: walks one transaction at a time, frames beats, handles abort/drain.
//   state    | meaning
//   ST_IDLE  | waiting for an info entry; no data accepted
//   ST_XFER  | forwarding beats into the output slice
//   ST_DRAIN | packet truncated by abort; residual beats discarded
module adma_dst_pkt_ctrl
  import adma_pkg::*;
#(
  parameter int unsigned CHN_NUM  = 4,
  parameter int unsigned CHN_W    = 2,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned TDEST_W  = 2,
  parameter int unsigned BYTE_AMT = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                info_vld,
  input  logic [CHN_W-1:0]    info_chn,
  input  logic [TDEST_W-1:0]  info_tdest,
  input  logic [LEN_W-1:0]    info_tlen,
  input  logic [BYTE_AMT-1:0] info_keep,
  output logic                info_pop,
  input  logic                wdata_vld,
  output logic                wdata_rdy,
  input  logic                slice_rdy,
  output logic                beat_vld,
  output logic                beat_last,
  output logic [BYTE_AMT-1:0] beat_keep,
  output logic [CHN_W-1:0]    cur_chn,
  output logic [TDEST_W-1:0]  cur_tdest,
  input  logic [CHN_NUM-1:0]  abort,
  output logic [CHN_NUM-1:0]  done,
  output logic [CHN_NUM-1:0]  err
);
  dst_state_e          state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d, tlen_q, tlen_d;
  logic                abort_q, abort_d;
  logic [CHN_W-1:0]    chn_q, chn_d;
  logic [TDEST_W-1:0]  tdest_q, tdest_d;
  logic [BYTE_AMT-1:0] keep_q, keep_d;
  logic [CHN_NUM-1:0]  done_q, done_d, err_q, err_d;
  logic                hs, at_end;

  assign hs     = wdata_vld & wdata_rdy;
  assign at_end = (cnt_q == tlen_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tlen_q  <= '0;
      abort_q <= 1'b0;
      chn_q   <= '0;
      tdest_q <= '0;
      keep_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tlen_q  <= tlen_d;
      abort_q <= abort_d;
      chn_q   <= chn_d;
      tdest_q <= tdest_d;
      keep_q  <= keep_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tlen_d  = tlen_q;
    abort_d = abort_q;
    chn_d   = chn_q;
    tdest_d = tdest_q;
    keep_d  = keep_q;
    done_d  = '0;
    err_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (info_vld) begin
          state_d = ST_XFER;
          chn_d   = info_chn;
          tdest_d = info_tdest;
          tlen_d  = info_tlen;
          keep_d  = (info_keep == '0) ? '1 : info_keep;
        end
      end
      ST_XFER: begin
        if (hs && at_end) begin
          // a fresh abort coinciding with the natural last beat is ignored
          state_d = ST_IDLE;
          cnt_d   = '0;
          abort_d = 1'b0;
          if (abort_q) err_d[chn_q] = 1'b1;
          else         done_d[chn_q] = 1'b1;
        end else begin
          if (abort[chn_q]) abort_d = 1'b1;
          if (hs) begin
            cnt_d = cnt_q + LEN_W'(1);
            if (abort_q) state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (hs) begin
          if (at_end) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            abort_d = 1'b0;
            err_d[chn_q] = 1'b1;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wdata_rdy = 1'b0;
    beat_vld  = 1'b0;
    info_pop  = 1'b0;
    case (state_q)
      ST_XFER: begin
        wdata_rdy = slice_rdy;
        beat_vld  = wdata_vld & slice_rdy;
        info_pop  = hs & at_end;
      end
      ST_DRAIN: begin
        wdata_rdy = 1'b1;
        info_pop  = hs & at_end;
      end
      default: ;
    endcase
    beat_last = at_end | abort_q;
    beat_keep = (at_end & ~abort_q) ? keep_q : '1;
  end

  assign cur_chn   = chn_q;
  assign cur_tdest = tdest_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: rtl/skid_buffer.sv
// Two-entry full skid buffer: registered ready and valid, 1 beat/cycle throughput.
module skid_buffer #(
  parameter int unsigned DW = 8
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
);
  logic          main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [DW-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic          s_hs, m_hs;

  assign s_ready = ~skid_vld_q;
  assign m_valid = main_vld_q;
  assign m_data  = main_data_q;
  assign s_hs    = s_valid & s_ready;
  assign m_hs    = main_vld_q & m_ready;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (m_hs) begin
      // skid occupied implies s_ready was low, so no new beat this cycle
      if (skid_vld_q) begin
        main_data_d = skid_data_q;
        skid_vld_d  = 1'b0;
      end else begin
        main_vld_d = s_hs;
        if (s_hs) main_data_d = s_data;
      end
    end else if (s_hs) begin
      if (!main_vld_q) begin
        main_vld_d  = 1'b1;
        main_data_d = s_data;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = s_data;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-2 depth; accepts a push while full if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int unsigned AW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adma_dm_dst_axis_pkt.sv
// Destination-side AXIS data mover: info FIFO -> packet controller -> output skid slice.
module adma_dm_dst_axis_pkt
  import adma_pkg::*;
#(
  parameter int unsigned DMA_CHN_NUM      = 4,
  parameter int unsigned MST_ID_W         = 5,
  parameter int unsigned ATX_LEN_W        = 8,
  parameter int unsigned DST_TDEST_W      = 2,
  parameter int unsigned ATX_DST_DATA_W   = 256,
  parameter int unsigned ATX_DST_BYTE_AMT = ATX_DST_DATA_W / 8,
  parameter int unsigned ATX_NUM_OSTD     = DMA_CHN_NUM,
  parameter int unsigned DMA_CHN_NUM_W    = clog2_min1(DMA_CHN_NUM)
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [DMA_CHN_NUM_W-1:0]        atx_chn_id,
  input  logic [DST_TDEST_W-1:0]          atx_tdest,
  input  logic [ATX_LEN_W-1:0]            atx_tlen,
  input  logic [ATX_DST_BYTE_AMT-1:0]     atx_tkeep_last,
  input  logic                            atx_vld,
  output logic                            atx_rdy,
  input  logic [ATX_DST_DATA_W-1:0]       atx_wdata,
  input  logic                            atx_wdata_vld,
  output logic                            atx_wdata_rdy,
  input  logic [DMA_CHN_NUM*MST_ID_W-1:0] atx_id,
  input  logic [DMA_CHN_NUM-1:0]          atx_abort,
  output logic [DMA_CHN_NUM-1:0]          atx_done,
  output logic [DMA_CHN_NUM-1:0]          atx_dst_err,
  output logic [MST_ID_W-1:0]             m_tid,
  output logic [DST_TDEST_W-1:0]          m_tdest,
  output logic [ATX_DST_DATA_W-1:0]       m_tdata,
  output logic [ATX_DST_BYTE_AMT-1:0]     m_tkeep,
  output logic [ATX_DST_BYTE_AMT-1:0]     m_tstrb,
  output logic                            m_tlast,
  output logic                            m_tvalid,
  input  logic                            m_tready
);
  localparam int unsigned INFO_W  = info_width(DMA_CHN_NUM_W, DST_TDEST_W, ATX_LEN_W, ATX_DST_BYTE_AMT);
  localparam int unsigned SLICE_W = MST_ID_W + DST_TDEST_W + ATX_DST_BYTE_AMT + 1 + ATX_DST_DATA_W;

  logic [INFO_W-1:0]           fifo_din, fifo_dout;
  logic                        fifo_full, fifo_empty, fifo_pop, info_push;
  logic [DMA_CHN_NUM_W-1:0]    head_chn, cur_chn;
  logic [DST_TDEST_W-1:0]      head_tdest, cur_tdest;
  logic [ATX_LEN_W-1:0]        head_tlen;
  logic [ATX_DST_BYTE_AMT-1:0] head_keep, beat_keep;
  logic                        beat_vld, beat_last, slice_rdy;
  logic [SLICE_W-1:0]          slice_din, slice_dout;
  logic [MST_ID_W-1:0]         id_arr [DMA_CHN_NUM];

  assign atx_rdy   = ~fifo_full;
  assign info_push = atx_vld & atx_rdy;
  assign fifo_din  = {atx_chn_id, atx_tdest, atx_tlen, atx_tkeep_last};
  assign {head_chn, head_tdest, head_tlen, head_keep} = fifo_dout;

  sync_fifo #(
    .DW    (INFO_W),
    .DEPTH (ATX_NUM_OSTD)
  ) u_info_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (info_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  adma_dst_pkt_ctrl #(
    .CHN_NUM  (DMA_CHN_NUM),
    .CHN_W    (DMA_CHN_NUM_W),
    .LEN_W    (ATX_LEN_W),
    .TDEST_W  (DST_TDEST_W),
    .BYTE_AMT (ATX_DST_BYTE_AMT)
  ) u_ctrl (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .info_vld   (~fifo_empty),
    .info_chn   (head_chn),
    .info_tdest (head_tdest),
    .info_tlen  (head_tlen),
    .info_keep  (head_keep),
    .info_pop   (fifo_pop),
    .wdata_vld  (atx_wdata_vld),
    .wdata_rdy  (atx_wdata_rdy),
    .slice_rdy  (slice_rdy),
    .beat_vld   (beat_vld),
    .beat_last  (beat_last),
    .beat_keep  (beat_keep),
    .cur_chn    (cur_chn),
    .cur_tdest  (cur_tdest),
    .abort      (atx_abort),
    .done       (atx_done),
    .err        (atx_dst_err)
  );

  for (genvar c = 0; c < DMA_CHN_NUM; c++) begin : g_id
    assign id_arr[c] = atx_id[c*MST_ID_W +: MST_ID_W];
  end

  // TSTRB always equals TKEEP, so only TKEEP travels through the slice
  assign slice_din = {id_arr[cur_chn], cur_tdest, beat_keep, beat_last, atx_wdata};

  skid_buffer #(
    .DW (SLICE_W)
  ) u_out_slice (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (beat_vld),
    .s_ready (slice_rdy),
    .s_data  (slice_din),
    .m_valid (m_tvalid),
    .m_ready (m_tready),
    .m_data  (slice_dout)
  );

  assign {m_tid, m_tdest, m_tkeep, m_tlast, m_tdata} = slice_dout;
  assign m_tstrb = m_tkeep;

endmodule

// File: tb/tb_adma_dm_dst_axis_pkt.sv
// Scoreboard bench for adma_dm_dst_axis_pkt: directed transactions, decoupled output monitor.
module tb_adma_dm_dst_axis_pkt;
  localparam int CHN = 4;
  localparam int IDW = 5;
  localparam int LENW = 8;
  localparam int TDW = 2;
  localparam int DW = 256;
  localparam int BA = 32;
  localparam int CW = 2;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [CW-1:0]     atx_chn_id = '0;
  logic [TDW-1:0]    atx_tdest = '0;
  logic [LENW-1:0]   atx_tlen = '0;
  logic [BA-1:0]     atx_tkeep_last = '0;
  logic              atx_vld = 1'b0;
  logic              atx_rdy;
  logic [DW-1:0]     atx_wdata = '0;
  logic              atx_wdata_vld = 1'b0;
  logic              atx_wdata_rdy;
  logic [CHN*IDW-1:0] atx_id = '0;
  logic [CHN-1:0]    atx_abort = '0;
  logic [CHN-1:0]    atx_done, atx_dst_err;
  logic [IDW-1:0]    m_tid;
  logic [TDW-1:0]    m_tdest;
  logic [DW-1:0]     m_tdata;
  logic [BA-1:0]     m_tkeep, m_tstrb;
  logic              m_tlast, m_tvalid;
  logic              m_tready = 1'b1;

  always #5 aclk = ~aclk;

  adma_dm_dst_axis_pkt #(
    .DMA_CHN_NUM(CHN), .MST_ID_W(IDW), .ATX_LEN_W(LENW), .DST_TDEST_W(TDW),
    .ATX_DST_DATA_W(DW), .ATX_DST_BYTE_AMT(BA), .ATX_NUM_OSTD(CHN), .DMA_CHN_NUM_W(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .atx_chn_id(atx_chn_id), .atx_tdest(atx_tdest), .atx_tlen(atx_tlen),
    .atx_tkeep_last(atx_tkeep_last), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .atx_wdata(atx_wdata), .atx_wdata_vld(atx_wdata_vld), .atx_wdata_rdy(atx_wdata_rdy),
    .atx_id(atx_id), .atx_abort(atx_abort), .atx_done(atx_done), .atx_dst_err(atx_dst_err),
    .m_tid(m_tid), .m_tdest(m_tdest), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tstrb(m_tstrb), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready)
  );

  typedef struct packed {
    logic [IDW-1:0] tid;
    logic [TDW-1:0] tdest;
    logic [BA-1:0]  keep;
    logic [BA-1:0]  strb;
    logic           last;
    logic [DW-1:0]  data;
  } beat_t;

  typedef struct packed {
    logic [CHN-1:0] done;
    logic [CHN-1:0] err;
  } evt_t;

  beat_t          exp_q[$];
  evt_t           evt_q[$];
  int             n_pass = 0;
  int             n_total = 0;
  logic [IDW-1:0] tid_tab [CHN];
  logic           tready_toggle = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [15:0] tag, input int b);
    logic [15:0] bb;
    bb = 16'(b);
    return {8{tag, bb}};
  endfunction

  // monitor: compares every AXIS handshake and every completion pulse against the queues
  initial begin : monitor
    beat_t got, held;
    logic  stall_q;
    stall_q = 1'b0;
    held = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stall_q = 1'b0;
      end else begin
        got = {m_tid, m_tdest, m_tkeep, m_tstrb, m_tlast, m_tdata};
        if (stall_q) chk("hold_stable", 512'({m_tvalid, got}), 512'({1'b1, held}));
        stall_q = m_tvalid & ~m_tready;
        held = got;
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) chk("unexpected_beat", 512'(got), 512'(0));
          else chk("beat", 512'(got), 512'(exp_q.pop_front()));
        end
        if ((|atx_done) || (|atx_dst_err)) begin
          if (evt_q.size() == 0) chk("unexpected_completion", 512'({atx_done, atx_dst_err}), 512'(0));
          else chk("completion", 512'({atx_done, atx_dst_err}), 512'(evt_q.pop_front()));
        end
      end
    end
  end

  initial begin : tready_drv
    forever begin
      tick();
      m_tready = tready_toggle ? ~m_tready : 1'b1;
    end
  end

  task automatic wait_rdy();
    int g = 0;
    while (!atx_wdata_rdy && g < 500) begin
      tick();
      g++;
    end
    if (!atx_wdata_rdy) chk("wdata_rdy_timeout", 512'(0), 512'(1));
  endtask

  task automatic push_info(input logic [CW-1:0] chn, input logic [TDW-1:0] tdest,
                           input logic [LENW-1:0] tlen, input logic [BA-1:0] keep);
    int g = 0;
    while (!atx_rdy && g < 500) begin
      tick();
      g++;
    end
    if (!atx_rdy) chk("atx_rdy_timeout", 512'(0), 512'(1));
    atx_chn_id = chn;
    atx_tdest = tdest;
    atx_tlen = tlen;
    atx_tkeep_last = keep;
    atx_vld = 1'b1;
    tick();
    atx_vld = 1'b0;
  endtask

  // ab_before: beat index before which atx_abort=ab_mask is pulsed (-1 = none)
  task automatic send_pkt(input logic [CW-1:0] chn, input logic [TDW-1:0] tdest, input int tlen,
                          input logic [BA-1:0] keep, input int ab_before, input logic [CHN-1:0] ab_mask,
                          input bit ab_with_last, input int n_send, input logic [15:0] tag);
    logic [BA-1:0] kexp;
    bit            trunc;
    evt_t          ev;
    beat_t         e;
    kexp  = (keep == '0) ? '1 : keep;
    trunc = ab_mask[chn] && (ab_before >= 0);
    if (n_send == tlen + 1) begin
      ev = '0;
      if (trunc) ev.err[chn] = 1'b1;
      else       ev.done[chn] = 1'b1;
      evt_q.push_back(ev);
    end
    for (int b = 0; b < n_send; b++) begin
      if (b == ab_before) begin
        wait_rdy();
        atx_abort = ab_mask;
        tick();
        atx_abort = '0;
      end
      wait_rdy();
      if (!(trunc && b > ab_before)) begin
        e.tid   = tid_tab[chn];
        e.tdest = tdest;
        e.last  = (trunc && b == ab_before) || (b == tlen);
        e.keep  = (b == tlen && !trunc) ? kexp : '1;
        e.strb  = e.keep;
        e.data  = mk_data(tag, b);
        exp_q.push_back(e);
      end
      atx_wdata = mk_data(tag, b);
      atx_wdata_vld = 1'b1;
      if (ab_with_last && b == tlen) atx_abort[chn] = 1'b1;
      tick();
      atx_wdata_vld = 1'b0;
      atx_abort = '0;
    end
  endtask

  task automatic wait_quiet();
    int g = 0;
    while ((exp_q.size() != 0 || evt_q.size() != 0 || m_tvalid) && g < 2000) begin
      tick();
      g++;
    end
    if (g >= 2000) chk("drain_timeout", 512'(0), 512'(1));
    tick();
    tick();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, 512'({atx_rdy, atx_wdata_rdy, atx_done, atx_dst_err, m_tvalid, m_tlast,
                    m_tid, m_tdest, m_tkeep, m_tstrb, m_tdata}),
              512'({1'b1, 338'd0}));
  endtask

  initial begin : stim
    tid_tab = '{5'd4, 5'd9, 5'd17, 5'd23};
    for (int c = 0; c < CHN; c++) atx_id[c*IDW +: IDW] = tid_tab[c];
    tick();
    tick();
    @(negedge aclk);
    chk_reset_outputs("reset_state");
    tick();
    aresetn = 1'b1;
    tick();

    // single 4-beat packet with narrow final keep
    push_info(2'd0, 2'd1, 8'd3, 32'h0000000F);
    send_pkt(2'd0, 2'd1, 3, 32'h0000000F, -1, 4'b0000, 1'b0, 4, 16'h0101);
    wait_quiet();

    // four outstanding transactions fill the info FIFO
    push_info(2'd0, 2'd0, 8'd0, 32'h00000000);
    push_info(2'd1, 2'd1, 8'd1, 32'h000000FF);
    push_info(2'd2, 2'd2, 8'd2, 32'h00000001);
    push_info(2'd3, 2'd3, 8'd1, 32'h80000000);
    chk("atx_rdy_full", 512'(atx_rdy), 512'(0));
    send_pkt(2'd0, 2'd0, 0, 32'h00000000, -1, 4'b0000, 1'b0, 1, 16'h0200);
    send_pkt(2'd1, 2'd1, 1, 32'h000000FF, -1, 4'b0000, 1'b0, 2, 16'h0201);
    send_pkt(2'd2, 2'd2, 2, 32'h00000001, -1, 4'b0000, 1'b0, 3, 16'h0202);
    send_pkt(2'd3, 2'd3, 1, 32'h80000000, -1, 4'b0000, 1'b0, 2, 16'h0203);
    wait_quiet();

    // abort on current channel after two beats: truncate then drain
    push_info(2'd2, 2'd2, 8'd7, 32'h000000F0);
    send_pkt(2'd2, 2'd2, 7, 32'h000000F0, 2, 4'b0100, 1'b0, 8, 16'h0300);
    wait_quiet();

    // aborts on other channels are ignored
    push_info(2'd2, 2'd1, 8'd3, 32'h00000003);
    send_pkt(2'd2, 2'd1, 3, 32'h00000003, 2, 4'b1011, 1'b0, 4, 16'h0400);
    wait_quiet();

    // abort while idle is ignored
    atx_abort = '1;
    tick();
    atx_abort = '0;
    tick();
    push_info(2'd1, 2'd0, 8'd1, 32'h00000000);
    send_pkt(2'd1, 2'd0, 1, 32'h00000000, -1, 4'b0000, 1'b0, 2, 16'h0500);
    wait_quiet();

    // abort before the first beat: 1-beat packet then drain
    push_info(2'd1, 2'd3, 8'd3, 32'h0000000F);
    send_pkt(2'd1, 2'd3, 3, 32'h0000000F, 0, 4'b0010, 1'b0, 4, 16'h0600);
    wait_quiet();

    // abort coinciding with the natural last beat completes normally
    push_info(2'd3, 2'd2, 8'd2, 32'h00000007);
    send_pkt(2'd3, 2'd2, 2, 32'h00000007, -1, 4'b0000, 1'b1, 3, 16'h0700);
    wait_quiet();

    // abort flagged just before the final beat: last beat all-ones keep, error
    push_info(2'd0, 2'd1, 8'd2, 32'h00000003);
    send_pkt(2'd0, 2'd1, 2, 32'h00000003, 2, 4'b0001, 1'b0, 3, 16'h0800);
    wait_quiet();

    // backpressure alternating every cycle
    tready_toggle = 1'b1;
    push_info(2'd1, 2'd2, 8'd15, 32'h00FFFF00);
    send_pkt(2'd1, 2'd2, 15, 32'h00FFFF00, -1, 4'b0000, 1'b0, 16, 16'h0900);
    wait_quiet();
    tready_toggle = 1'b0;
    tick();

    // maximum length
    push_info(2'd3, 2'd0, 8'd255, 32'h00000001);
    send_pkt(2'd3, 2'd0, 255, 32'h00000001, -1, 4'b0000, 1'b0, 256, 16'h0A00);
    wait_quiet();

    // reset mid-packet abandons it; next transaction completes normally
    push_info(2'd2, 2'd0, 8'd9, 32'h0000000F);
    send_pkt(2'd2, 2'd0, 9, 32'h0000000F, -1, 4'b0000, 1'b0, 5, 16'h0B00);
    tick();
    tick();
    aresetn = 1'b0;
    @(negedge aclk);
    chk_reset_outputs("reset_mid_packet");
    tick();
    aresetn = 1'b1;
    exp_q.delete();
    evt_q.delete();
    tick();
    push_info(2'd0, 2'd3, 8'd0, 32'h00000000);
    send_pkt(2'd0, 2'd3, 0, 32'h00000000, -1, 4'b0000, 1'b0, 1, 16'h0C00);
    wait_quiet();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
